// File: rtl/load_store_unit_if.sv
// Request/response handshake between execute and writeback, plus the DataMemory bus.
interface load_store_unit_if #(parameter int TAG_W = 5);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [TAG_W-1:0] req_rd;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_rd;
  logic             rsp_err;
  logic             WR;
  logic [31:0]      ADDRESS;
  logic [31:0]      BIN;
  logic [31:0]      DATAOUT;

  // The load/store unit side
  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata, req_rd, rsp_ready, DATAOUT,
    output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err, WR, ADDRESS, BIN
  );

  // Pipeline + DataMemory side
  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata, req_rd, rsp_ready, DATAOUT,
    input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_err, WR, ADDRESS, BIN
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-access stage: one request at a time, read-modify-write for sub-word
// stores, sign/zero extension for loads, one tagged response per request.
module load_store_unit #(
  parameter int MEM_WORDS = 256,
  parameter int TAG_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       op_q, op_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic             err_q, err_d;
  logic [31:0]      data_q, data_d;   // old word during RMW, response data in RESP

  logic             accept;
  logic             acc_err;
  logic             legal, misaligned, out_of_range;
  logic [4:0]       lane_sh;
  logic [31:0]      shifted, load_ext, lane_mask, merged;

  assign accept = bus.req_valid && (state_q == IDLE) && reset;

  // Acceptance-time error classification of the incoming request
  always_comb begin
    legal = 1'b0;
    if (bus.req_we) legal = (bus.req_op == 3'b000) || (bus.req_op == 3'b001) || (bus.req_op == 3'b010);
    else            legal = (bus.req_op == 3'b000) || (bus.req_op == 3'b001) || (bus.req_op == 3'b010) ||
                            (bus.req_op == 3'b100) || (bus.req_op == 3'b101);
    misaligned   = ((bus.req_op[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_op[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
    acc_err      = !legal || misaligned || out_of_range;
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_sh = {addr_q[1:0], 3'b000};
    shifted = bus.DATAOUT >> lane_sh;
    case (op_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'h0, shifted[7:0]};
      3'b101:  load_ext = {16'h0, shifted[15:0]};
      default: load_ext = bus.DATAOUT;
    endcase
    lane_mask = (op_q[1:0] == 2'b00) ? (32'h0000_00FF << lane_sh) : (32'h0000_FFFF << lane_sh);
    if (op_q[1:0] == 2'b10) merged = wdata_q;
    else                    merged = (data_q & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);
  end

  // State register and latched request; reset aborts any in-flight access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  // Next-state logic and datapath register updates
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (accept) begin
        we_d    = bus.req_we;
        op_d    = bus.req_op;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        rd_d    = bus.req_rd;
        err_d   = acc_err;
        data_d  = 32'h0;
        if (acc_err)                        state_d = RESP;
        else if (bus.req_we && bus.req_op == 3'b010) state_d = WRITE;
        else                                state_d = READ;
      end
      READ: begin
        // Stores keep the raw old word for the merge; loads keep the extended value
        data_d  = we_q ? bus.DATAOUT : load_ext;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: begin
        data_d  = 32'h0;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; everything idles at zero
  always_comb begin
    bus.req_ready = (state_q == IDLE) && reset;
    bus.WR        = (state_q == WRITE);
    bus.ADDRESS   = ((state_q == READ) || (state_q == WRITE)) ? {2'b00, addr_q[31:2]} : 32'h0;
    bus.BIN       = (state_q == WRITE) ? merged : 32'h0;
    bus.rsp_valid = (state_q == RESP);
    bus.rsp_data  = (state_q == RESP) ? data_q : 32'h0;
    bus.rsp_rd    = (state_q == RESP) ? rd_q : '0;
    bus.rsp_err   = (state_q == RESP) && err_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-level reference memory, expected responses
// queued at issue time and checked by an independent response/WR monitor.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.TAG_W(5)) bus();
  load_store_unit #(.MEM_WORDS(256), .TAG_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));

  // DataMemory stand-in
  logic [31:0] dmem [0:255];
  assign bus.DATAOUT = (bus.ADDRESS < 32'd256) ? dmem[bus.ADDRESS[7:0]] : 32'h0;
  always @(posedge clk) if (bus.WR && bus.ADDRESS < 32'd256) dmem[bus.ADDRESS[7:0]] <= bus.BIN;

  int total = 0, bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; logic err; logic [4:0] rd; int lat; int acc; } exp_t;
  typedef struct { logic [31:0] idx; logic [31:0] word; } wr_t;
  exp_t exp_q[$];
  wr_t  wr_q[$];
  logic [7:0] ref_b [0:1023];

  logic pending = 1'b0;
  logic skip_wr = 1'b0;
  int   hold_reqs = 0, hold_seen = 0, hold_n = 0;
  exp_t cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: what the response and the memory write should be, from byte-level rules
  function automatic void model(input logic we, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] data,
                                output logic err, output int lat, output logic [31:0] wword);
    int size; logic legal; logic [31:0] raw; logic [31:0] base;
    legal = we ? (op == 0 || op == 1 || op == 2) : (op == 0 || op == 1 || op == 2 || op == 4 || op == 5);
    size  = (op[1:0] == 0) ? 1 : (op[1:0] == 1) ? 2 : 4;
    err   = !legal || (addr % size != 0) || ((addr / 4) >= 256);
    data = 0; wword = 0; lat = 1;
    if (!err) begin
      base = addr & ~32'd3;
      if (we) begin
        for (int i = 0; i < size; i++) ref_b[addr + i] = wdata[8*i +: 8];
        wword = {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
        lat = (size == 4) ? 2 : 3;
      end else begin
        raw = 0;
        for (int i = 0; i < size; i++) raw = raw | (32'(ref_b[addr + i]) << (8*i));
        if (size == 1)      data = (op[2] || !raw[7])  ? raw : (raw | 32'hFFFF_FF00);
        else if (size == 2) data = (op[2] || !raw[15]) ? raw : (raw | 32'hFFFF_0000);
        else                data = raw;
        lat = 2;
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    exp_t e; wr_t w; int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_op = op;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
    n = 0;
    while (!bus.req_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin check("accept_timeout", 0, 1); bus.req_valid = 1'b0; return; end
    check("accept_while_rsp_open", 32'(exp_q.size()) + (pending ? 32'd1 : 32'd0), 0);
    model(we, op, addr, wdata, e.data, e.err, e.lat, w.word);
    e.rd = rd; e.acc = cyc + 1;
    exp_q.push_back(e);
    if (we && !e.err) begin w.idx = addr >> 2; wr_q.push_back(w); end
    @(posedge clk); #1 bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pending) && n < 200) begin @(negedge clk); n++; end
    check("drain_timeout", 32'(exp_q.size()) + (pending ? 32'd1 : 32'd0), 0);
  endtask

  // Monitor: WR pulses against expected writes, responses against the queue, rsp_ready driver
  always @(negedge clk) begin
    if (!reset) begin
      bus.rsp_ready = 1'b0;
      pending = 1'b0;
    end else begin
      if (bus.WR && !skip_wr) begin
        if (wr_q.size() == 0) check("unexpected_WR", 1, 0);
        else begin
          wr_t w; w = wr_q.pop_front();
          check("WR_ADDRESS", bus.ADDRESS, w.idx);
          check("WR_BIN", bus.BIN, w.word);
        end
      end
      if (bus.rsp_valid) begin
        check("rsp_bus_idle", {28'h0, bus.WR, bus.req_ready, bus.ADDRESS != 0, bus.BIN != 0}, 0);
        if (!pending) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 1, 0);
            cur.data = bus.rsp_data; cur.err = bus.rsp_err; cur.rd = bus.rsp_rd;
          end else begin
            cur = exp_q.pop_front();
            check("rsp_data", bus.rsp_data, cur.data);
            check("rsp_err", 32'(bus.rsp_err), 32'(cur.err));
            check("rsp_rd", 32'(bus.rsp_rd), 32'(cur.rd));
            check("rsp_latency", cyc + 1 - cur.acc, cur.lat);
          end
          pending = 1'b1;
        end else begin
          check("hold_data", bus.rsp_data, cur.data);
          check("hold_err", 32'(bus.rsp_err), 32'(cur.err));
          check("hold_rd", 32'(bus.rsp_rd), 32'(cur.rd));
        end
      end
      if (hold_reqs != hold_seen) begin hold_seen = hold_reqs; hold_n = 5; end
      if (hold_n > 0) begin
        bus.rsp_ready = 1'b0;
        if (bus.rsp_valid) hold_n--;
      end else bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (bus.rsp_valid && bus.rsp_ready) pending = 1'b0;
    end
  end

  initial begin
    logic [2:0] ops [0:9];
    logic [31:0] a;
    int widx, lo;
    ops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
    for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
    for (int i = 0; i < 256; i++) dmem[i] = 32'h0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.req_rd = 5'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", {25'h0, bus.req_ready, bus.rsp_valid, bus.WR, bus.ADDRESS != 0,
                            bus.BIN != 0, bus.rsp_data != 0, bus.rsp_err | (bus.rsp_rd != 0)}, 0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(bus.req_ready), 1);

    // Word store / load, then sub-word traffic on word 4
    issue(1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1);
    issue(0, 3'b010, 32'h10, 32'h0, 5'd2);
    issue(1, 3'b000, 32'h11, 32'h55, 5'd3);
    drain();
    check("dmem4_after_sb", dmem[4], 32'hDEAD55EF);
    issue(0, 3'b000, 32'h13, 32'h0, 5'd4);
    issue(0, 3'b100, 32'h13, 32'h0, 5'd5);
    issue(0, 3'b001, 32'h12, 32'h0, 5'd6);
    issue(0, 3'b101, 32'h12, 32'h0, 5'd7);
    issue(1, 3'b001, 32'h16, 32'hABCD8001, 5'd8);
    issue(0, 3'b001, 32'h16, 32'h0, 5'd9);

    // Errors
    issue(0, 3'b001, 32'h21, 32'h0, 5'd10);
    issue(1, 3'b010, 32'h400, 32'h12345678, 5'd11);
    issue(1, 3'b100, 32'h20, 32'h12345678, 5'd12);
    issue(0, 3'b011, 32'h20, 32'h0, 5'd13);
    issue(0, 3'b010, 32'h22, 32'h0, 5'd14);

    // Backpressure: hold RESP, with the next request already waiting
    hold_reqs++;
    issue(0, 3'b010, 32'h10, 32'h0, 5'd15);
    issue(0, 3'b000, 32'h10, 32'h0, 5'd16);
    drain();

    // Reset during the WRITE of a half store
    issue(1, 3'b010, 32'h40, 32'hCAFEF00D, 5'd17);
    drain();
    skip_wr = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_op = 3'b001;
    bus.req_addr = 32'h42; bus.req_wdata = 32'h1234; bus.req_rd = 5'd18;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    begin
      int n = 0;
      while (!bus.WR && n < 10) begin @(negedge clk); n++; end
      check("reset_test_WR_seen", 32'(bus.WR), 1);
    end
    #1 reset = 1'b0;
    #1 check("abort_outputs", {28'h0, bus.WR, bus.rsp_valid, bus.req_ready, bus.ADDRESS != 0}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    skip_wr = 1'b0;
    @(negedge clk);
    check("ready_after_abort", 32'(bus.req_ready), 1);
    repeat (3) begin @(negedge clk); check("no_rsp_after_abort", 32'(bus.rsp_valid), 0); end
    check("dmem16_unchanged", dmem[16], 32'hCAFEF00D);
    issue(0, 3'b010, 32'h40, 32'h0, 5'd19);

    // Sweep every word index, plus the first out-of-range one
    for (int i = 0; i < 256; i++) issue(1, 3'b010, 32'(i) << 2, 32'hFFFFFFFF, 5'(i));
    issue(1, 3'b010, 32'h400, 32'hFFFFFFFF, 5'd0);
    for (int i = 0; i < 256; i++) issue(0, 3'b010, 32'(i) << 2, 32'h0, 5'(i));
    issue(0, 3'b010, 32'h400, 32'h0, 5'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [2:0] op;
      op   = ops[$urandom_range(0, 9)];
      widx = $urandom_range(0, 259);
      lo   = $urandom_range(0, 3);
      if ($urandom_range(0, 3) != 0) lo = (op[1:0] == 2'b00) ? lo : (op[1:0] == 2'b01) ? (lo & 2) : 0;
      a = (32'(widx) << 2) | 32'(lo);
      issue(1'($urandom_range(0, 1)), op, a, $urandom, 5'($urandom_range(0, 31)));
    end
    drain();
    check("writes_left", 32'(wr_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
